// File: rtl/reaction_session.sv
// Session controller for the reaction core: runs ROUNDS rounds, classifies each
// round from the core status code, and reduces best time, hit/miss counts and average.
//
// state   | meaning
// IDLE    | results held, waiting for i_start
// ARMED   | rounds in progress, counting events
// DIVIDE  | sequential sum / hits for the average
// DONE    | one-cycle o_done pulse, back to IDLE
module reaction_session #(
  parameter int ROUNDS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_dst,
  input  logic [18:0] i_measured,
  output logic [15:0] o_rnd,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_round,
  output logic [2:0]  o_hits,
  output logic [2:0]  o_misses,
  output logic [18:0] o_best,
  output logic [18:0] o_avg
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DIVIDE, S_DONE} state_t;

  localparam logic [2:0]  ROUNDS_C = 3'(ROUNDS);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [18:0] ALL_ONES = 19'h7FFFF;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [2:0]  dst_q;
  logic        ev_hit;
  logic        ev_miss;
  logic [2:0]  round_inc;
  logic [21:0] sum;
  logic [21:0] sum_next;
  logic [21:0] quo;
  logic [2:0]  rem;
  logic [3:0]  rem_shift;
  logic [2:0]  rem_sub;
  logic        take;
  logic [4:0]  div_cnt;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    ev_hit    = (dst_q == 3'b010) && (i_dst == 3'b110);
    ev_miss   = ((dst_q == 3'b001) && (i_dst == 3'b011)) ||
                ((dst_q == 3'b010) && (i_dst == 3'b000));
    round_inc = o_round + 3'd1;
    sum_next  = sum + {3'b000, i_measured};
    // divisor is at most 7, so the partial remainder never needs more than 3 bits
    rem_shift = {rem, quo[21]};
    take      = rem_shift >= {1'b0, o_hits};
    rem_sub   = rem_shift[2:0] - o_hits;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_SEED;
      o_rnd    <= LFSR_SEED;
      dst_q    <= 3'b000;
      sum      <= '0;
      quo      <= '0;
      rem      <= '0;
      div_cnt  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_round  <= '0;
      o_hits   <= '0;
      o_misses <= '0;
      o_best   <= ALL_ONES;
      o_avg    <= ALL_ONES;
    end else begin
      lfsr  <= lfsr_next;
      o_rnd <= lfsr_next | 16'h1000;
      dst_q <= i_dst;
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            sum      <= '0;
            o_round  <= '0;
            o_hits   <= '0;
            o_misses <= '0;
            o_best   <= ALL_ONES;
            o_avg    <= ALL_ONES;
            o_busy   <= 1'b1;
            state    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (ev_hit) begin
            sum    <= sum_next;
            o_hits <= o_hits + 3'd1;
            if (i_measured < o_best) o_best <= i_measured;
          end
          if (ev_miss) o_misses <= o_misses + 3'd1;
          if (ev_hit || ev_miss) begin
            o_round <= round_inc;
            if (round_inc == ROUNDS_C) begin
              quo     <= ev_hit ? sum_next : sum;
              rem     <= '0;
              div_cnt <= 5'd22;
              state   <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          if (o_hits == 3'd0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            rem     <= take ? rem_sub : rem_shift[2:0];
            quo     <= {quo[20:0], take};
            div_cnt <= div_cnt - 5'd1;
            if (div_cnt == 5'd1) begin
              o_avg  <= {quo[17:0], take};
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        default: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_session.sv
// Directed bench for reaction_session: session vector table plus hand-written corner sequences.
module tb_reaction_session;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  dst = 3'b000;
  logic [18:0] meas = 19'd0;
  logic [15:0] o_rnd;
  logic        o_busy, o_done;
  logic [2:0]  o_round, o_hits, o_misses;
  logic [18:0] o_best, o_avg;

  reaction_session #(.ROUNDS(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dst(dst), .i_measured(meas),
    .o_rnd(o_rnd), .o_busy(o_busy), .o_done(o_done), .o_round(o_round),
    .o_hits(o_hits), .o_misses(o_misses), .o_best(o_best), .o_avg(o_avg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  localparam int K_HIT = 0, K_EARLY = 1, K_TMO = 2;

  typedef struct {
    int          kind[5];
    logic [18:0] m[5];
    int          hits;
    int          misses;
    logic [18:0] best;
    logic [18:0] avg;
    int          lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] d, input logic [18:0] m);
    dst  = d;
    meas = m;
    @(posedge clk);
    #1;
  endtask

  // t_edge is the cycle count right after the edge that registers the event
  task automatic do_event(input int k, input logic [18:0] m, output int t_edge);
    step(3'b001, 19'd0);
    case (k)
      K_HIT: begin
        step(3'b010, 19'd0);
        step(3'b110, m);
        t_edge = cyc;
      end
      K_EARLY: begin
        step(3'b011, 19'd0);
        t_edge = cyc;
      end
      default: begin
        step(3'b010, 19'd0);
        step(3'b000, 19'd0);
        t_edge = cyc;
      end
    endcase
    step(3'b000, 19'd0);
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    while (!o_done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", {31'd0, o_done}, 32'd1);
    done_cyc = cyc;
  endtask

  task automatic start_session();
    start = 1'b1;
    step(3'b000, 19'd0);
    start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic run_session(input vec_t v);
    int t, dc;
    t = 0;
    start_session();
    for (int i = 0; i < 5; i++) begin
      do_event(v.kind[i], v.m[i], t);
      chk("round_count", {29'd0, o_round}, i + 1);
    end
    wait_done(dc);
    chk("done_latency", dc - t, v.lat);
    chk("hits", {29'd0, o_hits}, v.hits);
    chk("misses", {29'd0, o_misses}, v.misses);
    chk("best", {13'd0, o_best}, {13'd0, v.best});
    chk("avg", {13'd0, o_avg}, {13'd0, v.avg});
    chk("busy_in_done", {31'd0, o_busy}, 32'd0);
    step(3'b000, 19'd0);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int t, dc, seen;
    vt[0].kind = '{K_HIT, K_HIT, K_HIT, K_HIT, K_HIT};
    vt[0].m    = '{19'd1000, 19'd400, 19'd700, 19'd900, 19'd500};
    vt[0].hits = 5; vt[0].misses = 0; vt[0].best = 19'd400; vt[0].avg = 19'd700; vt[0].lat = 22;

    vt[1].kind = '{K_HIT, K_EARLY, K_TMO, K_HIT, K_EARLY};
    vt[1].m    = '{19'd300, 19'd0, 19'd0, 19'd301, 19'd0};
    vt[1].hits = 2; vt[1].misses = 3; vt[1].best = 19'd300; vt[1].avg = 19'd300; vt[1].lat = 22;

    vt[2].kind = '{K_EARLY, K_EARLY, K_EARLY, K_EARLY, K_EARLY};
    vt[2].m    = '{19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
    vt[2].hits = 0; vt[2].misses = 5; vt[2].best = 19'h7FFFF; vt[2].avg = 19'h7FFFF; vt[2].lat = 1;

    vt[3].kind = '{K_TMO, K_TMO, K_TMO, K_TMO, K_HIT};
    vt[3].m    = '{19'd0, 19'd0, 19'd0, 19'd0, 19'd12345};
    vt[3].hits = 1; vt[3].misses = 4; vt[3].best = 19'd12345; vt[3].avg = 19'd12345; vt[3].lat = 22;

    vt[4].kind = '{K_HIT, K_HIT, K_HIT, K_HIT, K_HIT};
    vt[4].m    = '{19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF};
    vt[4].hits = 5; vt[4].misses = 0; vt[4].best = 19'h7FFFF; vt[4].avg = 19'h7FFFF; vt[4].lat = 22;

    // reset values, then one LFSR shift: ACE1 -> E270, with bit 12 forced
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rnd", {16'd0, o_rnd}, 32'h0000ACE1);
    chk("rst_best", {13'd0, o_best}, 32'h7FFFF);
    chk("rst_avg", {13'd0, o_avg}, 32'h7FFFF);
    chk("rst_counts", {23'd0, o_round, o_hits, o_misses}, 32'd0);
    chk("rst_flags", {30'd0, o_busy, o_done}, 32'd0);
    @(posedge clk);
    #1;
    chk("rnd_first_shift", {16'd0, o_rnd}, 32'h0000F270);

    for (int v = 0; v < 4; v++) run_session(vt[v]);

    // a HIT while IDLE leaves the held results alone
    do_event(K_HIT, 19'd77, t);
    chk("idle_hit_hits", {29'd0, o_hits}, 32'd1);
    chk("idle_hit_round", {29'd0, o_round}, 32'd5);
    chk("idle_hit_best", {13'd0, o_best}, 32'd12345);

    // start during ARMED and a 000->110 jump are both ignored
    start_session();
    do_event(K_HIT, 19'd50, t);
    do_event(K_EARLY, 19'd0, t);
    start = 1'b1;
    step(3'b000, 19'd0);
    start = 1'b0;
    chk("armed_start_round", {29'd0, o_round}, 32'd2);
    step(3'b110, 19'd10);
    step(3'b000, 19'd0);
    chk("jump_round", {29'd0, o_round}, 32'd2);
    chk("jump_hits", {29'd0, o_hits}, 32'd1);
    do_event(K_TMO, 19'd0, t);
    do_event(K_HIT, 19'd60, t);
    do_event(K_HIT, 19'd40, t);
    wait_done(dc);
    chk("ign_latency", dc - t, 32'd22);
    chk("ign_hits", {29'd0, o_hits}, 32'd3);
    chk("ign_misses", {29'd0, o_misses}, 32'd2);
    chk("ign_best", {13'd0, o_best}, 32'd40);
    chk("ign_avg", {13'd0, o_avg}, 32'd50);
    step(3'b000, 19'd0);

    // asynchronous reset ten cycles into DIVIDE
    start_session();
    for (int i = 0; i < 5; i++) do_event(K_HIT, 19'd100, t);
    while (cyc < t + 10) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rnd", {16'd0, o_rnd}, 32'h0000ACE1);
    chk("mid_rst_best", {13'd0, o_best}, 32'h7FFFF);
    chk("mid_rst_avg", {13'd0, o_avg}, 32'h7FFFF);
    chk("mid_rst_counts", {23'd0, o_round, o_hits, o_misses}, 32'd0);
    chk("mid_rst_flags", {30'd0, o_busy, o_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (o_done) seen++;
    end
    chk("no_done_after_rst", seen, 32'd0);
    chk("idle_after_rst_busy", {31'd0, o_busy}, 32'd0);

    run_session(vt[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
